beacon_pwm_ctrl: RTL and testbench
==================================

// Module: beacon_pwm_ctrl
// PURPOSE
//  Sequencing/configuration controller for the 3-phase beacon PWM drive.
//  Owns the rotation counter and decodes pwm1..pwm3 from programmable phase boundaries.
//  Adds graceful start/stop, burst gating (N periods on / M periods off) and
//  period-boundary-safe config updates via a valid/ready handshake.
//  Sits between the beacon host/config logic and the beacon LED drivers.
// PARAMETERS
//  PERIOD_W   16   width of period/boundary fields and of the rotation counter
//  BURST_W    8    width of burst on/off period counts
//  DEF_PERIOD 100  reset period in clk cycles
//  DEF_B1     34   reset phase-1/phase-2 boundary
//  DEF_B2     67   reset phase-2/phase-3 boundary
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst_n       in   1         asynchronous, active-low reset
//  en          in   1         level: run request
//  cfg_valid   in   1         config offer
//  cfg_ready   out  1         config slot free; transfer on cfg_valid&&cfg_ready
//  cfg_period  in   PERIOD_W  counter period P (count runs 0..P-1)
//  cfg_b1      in   PERIOD_W  pwm1 while count<B1
//  cfg_b2      in   PERIOD_W  pwm2 while B1<=count<B2; pwm3 while B2<=count<P
//  cfg_bon     in   BURST_W   periods on per burst; 0 = continuous
//  cfg_boff    in   BURST_W   periods off per burst (ignored if cfg_bon==0)
//  cfg_err     out  1         1-cycle pulse: offered config rejected
//  pwm1..pwm3  out  1 each    phase outputs, at most one high at any time
//  period_tick out  1         1-cycle pulse on last count of every running period
//  busy        out  1         state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE, count 0, active cfg = defaults, bon=0, boff=0,
//    pending empty; pwm*=0, cfg_ready=1, cfg_err=0, period_tick=0, busy=0.
//  - Outputs are combinational decode of registered state/count/active cfg.
//  - FSM: IDLE, RUN_ON, RUN_OFF, DRAIN.
//    IDLE:   count held 0; en=1 -> RUN_ON next cycle (pwm1 high that cycle if B1>0).
//    RUN_ON: pwm decoded; en=0 -> DRAIN; at wrap, burst count done and
//            boff>0 -> RUN_OFF.
//    RUN_OFF: pwm*=0, count keeps running; en=0 -> IDLE next cycle; after boff
//            periods -> RUN_ON.
//    DRAIN:  pwm decoded; finish current period -> IDLE at wrap; en=1 -> RUN_ON
//            with no gap in the pattern.
//  - Counter: count==P-1 -> 0 (wrap), else +1; only in RUN_ON/RUN_OFF/DRAIN.
//  - Burst counter restarts at 0 on entry to RUN_ON and RUN_OFF; increments on each wrap.
//  - Config: accepted config goes to a pending register; cfg_ready=0 while pending.
//    Pending -> active at next wrap, or next cycle if IDLE. Apply also resets
//    the burst counter. Wrap and apply in same cycle: new cfg governs count 0.
//  - Validation at accept: reject (cfg_err pulse next cycle, nothing stored,
//    cfg_ready stays 1) if P==0, B1>B2, or B2>P. B1==B2 or B2==P give empty phases (legal).
//  - en toggles and cfg transfers in the same cycle are both honoured.
// STRUCTURE
//  - Package beacon_pkg: state enum (IDLE, RUN_ON, RUN_OFF, DRAIN),
//    cfg struct {period,b1,b2,bon,boff}, default constants.
//  - Sub-module beacon_phase_counter: counter, wrap flag, 3-way boundary decode.
//    The top level keeps the FSM, burst counting and the config pending/active registers.
// TESTING
//  1 reset, en=1, defaults -> pwm1 34 cyc, pwm2 33, pwm3 33; tick every 100 cyc.
//  2 running, cfg P=10,B1=2,B2=5 at count 40 -> cfg_ready=0 until wrap; next period 2/3/5.
//  3 cfg bon=2,boff=1 -> 2 active periods, 1 all-low period, tick continues, repeats.
//  4 en=0 at count 50 -> pattern to 99, then IDLE/busy=0; re-en at 70 -> no gap.
//  5 cfg B1=8,B2=5 -> cfg_err pulse, cfg_ready stays 1, active pattern unchanged.
//  6 rst_n low at count 60 mid-cycle -> pwm*=0 immediately; defaults on restart.

Source files
------------

// File: rtl/beacon_pkg.sv
// Shared types and reset constants for the beacon PWM controller.
package beacon_pkg;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned BURST_W  = 8;

    localparam logic [PERIOD_W-1:0] RST_PERIOD = 16'd100;
    localparam logic [PERIOD_W-1:0] RST_B1     = 16'd34;
    localparam logic [PERIOD_W-1:0] RST_B2     = 16'd67;

    typedef enum logic [1:0] {IDLE, RUN_ON, RUN_OFF, DRAIN} state_e;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] b1;
        logic [PERIOD_W-1:0] b2;
        logic [BURST_W-1:0]  bon;
        logic [BURST_W-1:0]  boff;
    } cfg_t;

    // B1==B2 or B2==P only empty a phase; anything else out of order is rejected.
    function automatic logic cfg_ok(cfg_t c);
        return (c.period != '0) && (c.b1 <= c.b2) && (c.b2 <= c.period);
    endfunction

endpackage

// File: rtl/beacon_pwm_ctrl_if.sv
// Config handshake bus between the beacon host and the PWM controller.
interface beacon_pwm_ctrl_if;
    import beacon_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [PERIOD_W-1:0] cfg_period;
    logic [PERIOD_W-1:0] cfg_b1;
    logic [PERIOD_W-1:0] cfg_b2;
    logic [BURST_W-1:0]  cfg_bon;
    logic [BURST_W-1:0]  cfg_boff;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_period, cfg_b1, cfg_b2, cfg_bon, cfg_boff,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_b1, cfg_b2, cfg_bon, cfg_boff,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/beacon_phase_counter.sv
// Rotation counter with last-count flag and three-way phase boundary decode.
module beacon_phase_counter
    import beacon_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] b1,
    input  logic [PERIOD_W-1:0] b2,
    output logic                at_last,
    output logic                ph1,
    output logic                ph2,
    output logic                ph3
);

    logic [PERIOD_W-1:0] count_q;

    // Anything other than an in-period advance parks the count at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (run && !at_last) begin
            count_q <= count_q + 1'b1;
        end else begin
            count_q <= '0;
        end
    end

    assign at_last = (count_q == period - 1'b1);
    assign ph1     = (count_q < b1);
    assign ph2     = (count_q >= b1) && (count_q < b2);
    assign ph3     = (count_q >= b2) && (count_q < period);

endmodule

// File: rtl/beacon_pwm_ctrl.sv
// 3-phase beacon PWM sequencer: run/drain FSM, burst gating, boundary-safe config.
module beacon_pwm_ctrl
    import beacon_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] DEF_PERIOD = RST_PERIOD,
    parameter logic [PERIOD_W-1:0] DEF_B1     = RST_B1,
    parameter logic [PERIOD_W-1:0] DEF_B2     = RST_B2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    beacon_pwm_ctrl_if.slave  cfg_bus,
    output logic              pwm1,
    output logic              pwm2,
    output logic              pwm3,
    output logic              period_tick,
    output logic              busy
);

    localparam cfg_t DefCfg = '{period: DEF_PERIOD, b1: DEF_B1, b2: DEF_B2,
                                bon: '0, boff: '0};

    state_e             state_q;
    cfg_t               act_q, pend_q, offer;
    logic               pend_v_q, err_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W:0]   burst_next;
    logic               running, at_last, wrap, apply, accept, to_idle, run, drive;
    logic               on_done, off_done, ph1, ph2, ph3;

    assign offer = '{period: cfg_bus.cfg_period, b1: cfg_bus.cfg_b1, b2: cfg_bus.cfg_b2,
                     bon: cfg_bus.cfg_bon, boff: cfg_bus.cfg_boff};

    assign running    = (state_q != IDLE);
    assign wrap       = running && at_last;
    assign accept     = cfg_bus.cfg_valid && !pend_v_q;
    assign apply      = pend_v_q && (wrap || state_q == IDLE);
    assign burst_next = {1'b0, burst_q} + 1'b1;
    assign on_done    = (burst_next >= {1'b0, act_q.bon});
    assign off_done   = (burst_next >= {1'b0, act_q.boff});

    // Off-burst stops at once; driving states stop only once the period ends.
    assign to_idle = !en && ((state_q == RUN_OFF) ||
                             ((state_q == RUN_ON || state_q == DRAIN) && wrap));
    assign run     = running && !to_idle;

    beacon_phase_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .period  (act_q.period),
        .b1      (act_q.b1),
        .b2      (act_q.b2),
        .at_last (at_last),
        .ph1     (ph1),
        .ph2     (ph2),
        .ph3     (ph3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            act_q    <= DefCfg;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            err_q    <= 1'b0;
            burst_q  <= '0;
        end else begin
            err_q <= accept && !cfg_ok(offer);
            if (accept && cfg_ok(offer)) begin
                pend_q   <= offer;
                pend_v_q <= 1'b1;
            end
            if (apply) begin
                act_q    <= pend_q;
                pend_v_q <= 1'b0;
            end
            if (wrap) burst_q <= burst_next[BURST_W-1:0];

            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN_ON;
                        burst_q <= '0;
                    end
                end
                RUN_ON: begin
                    if (to_idle) begin
                        state_q <= IDLE;
                    end else if (!en) begin
                        state_q <= DRAIN;
                    end else if (wrap && !apply && act_q.bon != '0 && act_q.boff != '0
                                 && on_done) begin
                        state_q <= RUN_OFF;
                        burst_q <= '0;
                    end
                end
                RUN_OFF: begin
                    // A freshly applied config always restarts with an on-burst.
                    if (to_idle) begin
                        state_q <= IDLE;
                    end else if (wrap && (apply || off_done)) begin
                        state_q <= RUN_ON;
                        burst_q <= '0;
                    end
                end
                DRAIN: begin
                    if (to_idle) begin
                        state_q <= IDLE;
                    end else if (en) begin
                        state_q <= RUN_ON;
                        burst_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (apply) burst_q <= '0;
        end
    end

    assign drive             = (state_q == RUN_ON) || (state_q == DRAIN);
    assign pwm1              = drive && ph1;
    assign pwm2              = drive && ph2;
    assign pwm3              = drive && ph3;
    assign period_tick       = wrap;
    assign busy              = running;
    assign cfg_bus.cfg_ready = !pend_v_q;
    assign cfg_bus.cfg_err   = err_q;

endmodule

// File: tb/tb_beacon_pwm_ctrl.sv
// Directed and randomized checks of beacon_pwm_ctrl against a period-arithmetic model.
module tb_beacon_pwm_ctrl;
    import beacon_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic pwm1, pwm2, pwm3, period_tick, busy;

    beacon_pwm_ctrl_if bus ();

    beacon_pwm_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_bus     (bus),
        .pwm1        (pwm1),
        .pwm2        (pwm2),
        .pwm3        (pwm3),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c1, c2, c3, ct, cb;

    // Model: active/pending config, run flags, age since schedule origin, burst base period.
    int mp, mb1, mb2, mbon, mboff;
    int pp, pb1, pb2, pbon, pboff;
    bit pv, m_run, m_stop, m_err;
    int m_age, m_base;

    task automatic chk(string tag, logic obs, logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mp = 100; mb1 = 34; mb2 = 67; mbon = 0; mboff = 0;
        pv = 0; m_run = 0; m_stop = 0; m_err = 0; m_age = 0; m_base = 0;
    endtask

    // Phase outputs are live unless the schedule places this period in an off-burst.
    function automatic bit m_on();
        int k;
        if (!m_run) return 1'b0;
        if (m_stop || mbon == 0) return 1'b1;
        k = m_age / mp - m_base;
        return (k % (mbon + mboff)) < mbon;
    endfunction

    task automatic check_outputs();
        int pos;
        bit on;
        pos = m_age % mp;
        on  = m_on();
        chk("pwm1", pwm1, on && pos < mb1);
        chk("pwm2", pwm2, on && pos >= mb1 && pos < mb2);
        chk("pwm3", pwm3, on && pos >= mb2);
        chk("period_tick", period_tick, m_run && pos == mp - 1);
        chk("busy", busy, m_run);
        chk("cfg_ready", bus.cfg_ready, !pv);
        chk("cfg_err", bus.cfg_err, m_err);
    endtask

    task automatic model_step();
        bit wrap, on, acc, ok, do_apply;
        int p, b1, b2;
        p  = int'(bus.cfg_period);
        b1 = int'(bus.cfg_b1);
        b2 = int'(bus.cfg_b2);
        wrap     = m_run && (m_age % mp == mp - 1);
        on       = m_on();
        acc      = bus.cfg_valid && !pv;
        ok       = (p != 0) && (b1 <= b2) && (b2 <= p);
        do_apply = pv && (!m_run || wrap);
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_stop = 0; m_age = 0; m_base = 0;
            end
        end else if (!en && (!on || wrap)) begin
            m_run = 0; m_stop = 0; m_age = 0;
        end else begin
            if (!en) m_stop = 1;
            else if (m_stop) begin
                m_stop = 0;
                m_base = (m_age + 1) / mp;
            end
            m_age++;
        end
        if (do_apply) begin
            mp = pp; mb1 = pb1; mb2 = pb2; mbon = pbon; mboff = pboff;
            pv = 0; m_age = 0; m_base = 0;
        end
        m_err = acc && !ok;
        if (acc && ok) begin
            pv = 1; pp = p; pb1 = b1; pb2 = b2;
            pbon = int'(bus.cfg_bon); pboff = int'(bus.cfg_boff);
        end
    endtask

    // Called at a falling edge with inputs already set for the coming rising edge.
    task automatic tick_cycle();
        check_outputs();
        c1 += int'(pwm1); c2 += int'(pwm2); c3 += int'(pwm3);
        ct += int'(period_tick); cb += int'(busy);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clr_counts();
        c1 = 0; c2 = 0; c3 = 0; ct = 0; cb = 0;
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic run_until_pos(int target);
        int n = 0;
        while ((m_age % mp) != target && n < 400) begin
            tick_cycle();
            n++;
        end
        if (n >= 400) begin
            n_tests++; n_fail++;
            $error("FAIL wait_pos: observed timeout required count %0d", target);
        end
    endtask

    task automatic drive_cfg(int p, int b1, int b2, int bon, int boff);
        bus.cfg_period = PERIOD_W'(p);
        bus.cfg_b1     = PERIOD_W'(b1);
        bus.cfg_b2     = PERIOD_W'(b2);
        bus.cfg_bon    = BURST_W'(bon);
        bus.cfg_boff   = BURST_W'(boff);
    endtask

    task automatic offer(int p, int b1, int b2, int bon, int boff);
        drive_cfg(p, b1, b2, bon, boff);
        bus.cfg_valid = 1'b1;
        tick_cycle();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.cfg_valid = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        model_reset();
        clr_counts();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Defaults: 34/33/33 split and one tick per 100 cycles.
        en = 1'b1;
        tick_cycle();
        clr_counts();
        run_cycles(100);
        chk_int("t1_pwm1_len", c1, 34);
        chk_int("t1_pwm2_len", c2, 33);
        chk_int("t1_pwm3_len", c3, 33);
        chk_int("t1_ticks", ct, 1);

        // Mid-period config waits for the wrap.
        run_until_pos(40);
        offer(10, 2, 5, 0, 0);
        chk("t2_ready_held_low", bus.cfg_ready, 1'b0);
        run_until_pos(0);
        clr_counts();
        run_cycles(10);
        chk_int("t2_pwm1_len", c1, 2);
        chk_int("t2_pwm2_len", c2, 3);
        chk_int("t2_pwm3_len", c3, 5);

        // Burst 2 on / 1 off.
        offer(10, 2, 5, 2, 1);
        run_until_pos(0);
        clr_counts();
        run_cycles(30);
        chk_int("t3_pwm1_len", c1, 4);
        chk_int("t3_pwm3_len", c3, 10);
        chk_int("t3_ticks", ct, 3);

        // Drain with re-enable at 70, then a full drain.
        offer(100, 34, 67, 0, 0);
        run_until_pos(0);
        run_until_pos(50);
        en = 1'b0;
        run_until_pos(70);
        en = 1'b1;
        clr_counts();
        run_cycles(30);
        chk_int("t4_no_gap_pwm3", c3, 30);
        chk_int("t4_no_gap_busy", cb, 30);
        run_until_pos(50);
        en = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            tick_cycle();
            n++;
        end
        chk_int("t4_drain_len", n, 50);

        // Rejected config.
        offer(10, 8, 5, 0, 0);
        chk("t5_err_pulse", bus.cfg_err, 1'b1);
        chk("t5_ready_kept", bus.cfg_ready, 1'b1);
        run_cycles(3);

        // Asynchronous reset mid-period.
        en = 1'b1;
        tick_cycle();
        run_until_pos(60);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pwm1_async", pwm1, 1'b0);
        chk("t6_pwm2_async", pwm2, 1'b0);
        chk("t6_pwm3_async", pwm3, 1'b0);
        chk("t6_busy_async", busy, 1'b0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        tick_cycle();
        clr_counts();
        run_cycles(100);
        chk_int("t6_pwm1_restart", c1, 34);
        chk_int("t6_pwm3_restart", c3, 33);

        // Random en toggles and config offers, including invalid and degenerate ones.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            bus.cfg_valid = ($urandom_range(0, 7) == 0);
            drive_cfg($urandom_range(0, 12), $urandom_range(0, 13), $urandom_range(0, 13),
                      $urandom_range(0, 3), $urandom_range(0, 2));
            tick_cycle();
        end
        bus.cfg_valid = 1'b0;
        tick_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
